lut_serial_adder: RTL and testbench

LUT_SERIAL_ADDER -- requirements
Module: lut_serial_adder

---
 rtl/lut_adder_pkg.sv | 20 ++
 rtl/lut_full_adder.sv | 22 ++
 rtl/lut_serial_adder.sv | 146 ++++++++++++++
 tb/tb_lut_serial_adder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lut_adder_pkg.sv
// Shared definitions for the LUT-based bit-serial adder: FSM state
// encoding and the 3-input truth tables of the full-adder cell.
package lut_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Truth tables indexed by {a, b, cin}.
    localparam logic [7:0] LUT_SUM_INIT   = 8'h96;  // a ^ b ^ cin
    localparam logic [7:0] LUT_CARRY_INIT = 8'hE8;  // majority(a, b, cin)

    // Evaluate a 3-input lookup table.
    function automatic logic lut3(input logic [7:0] init, input logic [2:0] idx);
        return init[idx];
    endfunction

endpackage

// File: rtl/lut_full_adder.sv
// One full-adder cell built from two 3-input LUTs whose contents are
// supplied as parameters.
module lut_full_adder
    import lut_adder_pkg::*;
#(
    parameter logic [7:0] SUM_INIT   = LUT_SUM_INIT,
    parameter logic [7:0] CARRY_INIT = LUT_CARRY_INIT
) (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic S,
    output logic COUT
);

    logic [2:0] w_idx;

    assign w_idx = {A, B, CIN};
    assign S     = lut3(SUM_INIT, w_idx);
    assign COUT  = lut3(CARRY_INIT, w_idx);

endmodule

// File: rtl/lut_serial_adder.sv
// Bit-serial adder/subtractor: one LUT full-adder cell evaluated per clock,
// LSB first, with the carry held in a flip-flop between bits. The result
// registers only update when an operation completes.
module lut_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF
);

    // The DONE state literal shares its name with the DONE port, so the
    // states are always referenced through the package scope.
    import lut_adder_pkg::state_t;
    import lut_adder_pkg::LUT_SUM_INIT;
    import lut_adder_pkg::LUT_CARRY_INIT;

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-2:0] r_res;       // sum bits produced so far, MSB-aligned
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sum;
    logic             w_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    lut_full_adder #(
        .SUM_INIT   (LUT_SUM_INIT),
        .CARRY_INIT (LUT_CARRY_INIT)
    ) u_fa (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .CIN  (r_carry),
        .S    (w_sum),
        .COUT (w_cout)
    );

    assign w_last     = (r_cnt == LAST_BIT);
    // New sum bit enters at the top; after WIDTH bits the LSB lands at bit 0.
    assign w_res_next = {w_sum, r_res};

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= lut_adder_pkg::IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and status outputs.
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            lut_adder_pkg::IDLE: begin
                if (START) w_state_next = lut_adder_pkg::RUN;
            end
            lut_adder_pkg::RUN: begin
                w_busy = 1'b1;
                if (w_last) w_state_next = lut_adder_pkg::DONE;
            end
            lut_adder_pkg::DONE: begin
                w_done       = 1'b1;
                w_state_next = lut_adder_pkg::IDLE;
            end
            default: w_state_next = lut_adder_pkg::IDLE;
        endcase
    end

    // Operand capture, per-bit evaluation and result load.
    // NOTE: the datapath and result registers are reset as well, so a reset
    // mid-operation clears the visible result instead of leaving stale data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                lut_adder_pkg::IDLE: begin
                    if (START) begin
                        // Subtraction is A + ~B + 1; CIN is ignored then.
                        r_a     <= A;
                        r_b     <= SUB ? ~B : B;
                        r_carry <= SUB ? 1'b1 : CIN;
                        r_cnt   <= '0;
                    end
                end
                lut_adder_pkg::RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    r_res   <= w_res_next[WIDTH-1:1];
                    if (w_last) begin
                        // r_carry is the carry into the MSB during the last bit.
                        r_s    <= w_res_next;
                        r_cout <= w_cout;
                        r_ovf  <= w_cout ^ r_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY = w_busy;
    assign DONE = w_done;
    assign S    = r_s;
    assign COUT = r_cout;
    assign OVF  = r_ovf;

endmodule

// File: tb/tb_lut_serial_adder.sv
// Self-checking bench for lut_serial_adder (WIDTH = 8).
module tb_lut_serial_adder;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       SUB = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       CIN = 1'b0;
    logic       BUSY;
    logic       DONE;
    logic [7:0] S;
    logic       COUT;
    logic       OVF;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] prev_s = 8'h00;

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[16];

    lut_serial_adder #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .SUB   (SUB),
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .S     (S),
        .COUT  (COUT),
        .OVF   (OVF)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Launch one operation, scramble the inputs after the sampling edge,
    // observe 14 cycles and compare result, latency and handshake.
    // glitch_k > 0 pulses START with other operands during that cycle.
    task automatic do_op(input logic sub, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] es, input logic ec,
                         input logic eo, input int glitch_k, input logic rel_rst,
                         input string tag);
        int   busy_n = 0;
        int   done_n = 0;
        int   done_k = 0;
        logic s_ok   = 1'b1;
        logic excl   = 1'b1;
        @(negedge CLK);
        if (rel_rst) RST = 1'b0;
        START = 1'b1; SUB = sub; A = a; B = b; CIN = cin;
        @(posedge CLK);
        #1;
        START = 1'b0; SUB = ~sub; A = ~a; B = b ^ 8'h5A; CIN = ~cin;
        for (int k = 1; k <= 14; k++) begin
            @(negedge CLK);
            if (k == glitch_k) begin
                START = 1'b1; SUB = 1'b0; A = 8'hC3; B = 8'h3C; CIN = 1'b1;
            end else if (k == glitch_k + 1) begin
                START = 1'b0;
            end
            if (BUSY) busy_n++;
            if (DONE) begin
                done_n++;
                if (done_k == 0) done_k = k;
            end
            if (BUSY && DONE) excl = 1'b0;
            if (done_k == 0 && S !== prev_s) s_ok = 1'b0;
            if (done_k != 0 && k > done_k && S !== es) s_ok = 1'b0;
        end
        check({tag, ".s"},       S, es);
        check({tag, ".cout"},    COUT, ec);
        check({tag, ".ovf"},     OVF, eo);
        check({tag, ".done_at"}, done_k, 9);
        check({tag, ".done_n"},  done_n, 1);
        check({tag, ".busy_n"},  busy_n, 8);
        check({tag, ".s_hold"},  s_ok, 1'b1);
        check({tag, ".excl"},    excl, 1'b1);
        prev_s = es;
    endtask

    initial begin
        logic idle_ok;

        //            sub   a      b      cin   s      cout  ovf
        vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'h01, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};

        // Asynchronous reset before any clock edge.
        #2 RST = 1'b1;
        #1;
        check("rst.busy", BUSY, 1'b0);
        check("rst.done", DONE, 1'b0);
        check("rst.s",    S, 8'h00);
        check("rst.cout", COUT, 1'b0);
        check("rst.ovf",  OVF, 1'b0);

        // Vector table; the first operation starts on the first edge after release.
        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].s, vecs[i].cout, vecs[i].ovf, 0, (i == 0),
                  $sformatf("vec%0d", i));
        end

        // START pulsed mid-RUN with other operands must be ignored.
        do_op(1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3, 1'b0, "glitch");

        // Reset while bit 4 is being computed.
        @(negedge CLK);
        START = 1'b1; SUB = 1'b0; A = 8'h33; B = 8'h11; CIN = 1'b0;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (4) @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("abort.busy", BUSY, 1'b0);
        check("abort.done", DONE, 1'b0);
        check("abort.s",    S, 8'h00);
        check("abort.cout", COUT, 1'b0);
        check("abort.ovf",  OVF, 1'b0);
        idle_ok = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (BUSY || DONE) idle_ok = 1'b0;
        end
        check("abort.quiet", idle_ok, 1'b1);
        prev_s = 8'h00;

        // Fresh operation started on the first edge after reset release.
        do_op(1'b0, 8'h33, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0, 0, 1'b1, "recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
